// File: rtl/parity_pkg.sv
// Shared definitions for the parity checking family: FSM states, parity-mode
// constants and the frame index width helper.
package parity_pkg;

  typedef enum logic {
    ST_DATA  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Index register must hold 0..frame_len-1 and is never narrower than one bit.
  function automatic int idx_width(input int frame_len);
    return (frame_len <= 1) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/parity_word_calc.sv
// Combinational per-word parity check: err=1 when data+par ones-count does not
// match the selected mode (even or odd).
module parity_word_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              mode,
  output logic              err
);

  assign err = (^data) ^ par ^ mode;

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming parity checker: per-word parity plus a longitudinal XOR check word
// closing each frame of FRAME_LEN data words, with a saturating error counter.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              clr_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_word_err,
  output logic              out_last,
  output logic              out_frame_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int IDX_W = idx_width(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] lrc;
  logic              sticky_err;
  logic              mode_q;

  logic              accept;
  logic              first_word;
  logic              mode_eff;
  logic              word_err;
  logic [DATA_W-1:0] lrc_base;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_word = (state == ST_DATA) && (idx == '0);
  // The first data word of a frame is judged by the mode it loads.
  assign mode_eff   = first_word ? odd_mode : mode_q;
  assign lrc_base   = first_word ? '0 : lrc;

  parity_word_calc #(.DATA_W(DATA_W)) u_word_calc (
    .data (in_data),
    .par  (in_par),
    .mode (mode_eff),
    .err  (word_err)
  );

  // Frame FSM and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_DATA;
      idx           <= '0;
      lrc           <= '0;
      sticky_err    <= 1'b0;
      mode_q        <= PAR_EVEN;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_word_err  <= 1'b0;
      out_last      <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_valid    <= 1'b1;
        out_data     <= in_data;
        out_word_err <= word_err;
        case (state)
          ST_DATA: begin
            out_last      <= 1'b0;
            out_frame_err <= 1'b0;
            if (first_word) mode_q <= odd_mode;
            lrc        <= lrc_base ^ in_data;
            sticky_err <= (first_word ? 1'b0 : sticky_err) | word_err;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= ST_CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          ST_CHECK: begin
            out_last      <= 1'b1;
            out_frame_err <= sticky_err | word_err | (in_data != lrc);
            idx           <= '0;
            state         <= ST_DATA;
          end
          default: state <= ST_DATA;
        endcase
      end
    end
  end

  // Error counter: clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      err_count <= '0;
    end else if (accept && word_err) begin
      err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: a frame-level reference model
// predicts each output word; a monitor compares whenever a word transfers.
module tb_parity_frame_checker;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              odd_mode = 1'b0;
  logic              clr_count = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_par = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_word_err;
  logic              out_last;
  logic              out_frame_err;
  logic [CNT_W-1:0]  err_count;

  parity_frame_checker #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .clr_count(clr_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_word_err(out_word_err), .out_last(out_last), .out_frame_err(out_frame_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              we;
    logic              last;
    logic              fe;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: the data words and their errors seen so far in this frame.
  logic [DATA_W-1:0] fw_d[$];
  bit                fw_err[$];
  bit                m_mode = 1'b0;
  int                m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit word_error(input logic [DATA_W-1:0] d, input logic p, input bit mode);
    bit odd_ones;
    odd_ones = ($countones({d, p}) % 2) == 1;
    return odd_ones != mode;
  endfunction

  function automatic logic [DATA_W-1:0] model_lrc();
    logic [DATA_W-1:0] x = '0;
    foreach (fw_d[i]) x ^= fw_d[i];
    return x;
  endfunction

  task automatic model_accept(input logic [DATA_W-1:0] d, input logic p, input logic om,
                              input logic clr);
    exp_t e;
    bit   err;
    if (fw_d.size() == 0) m_mode = om;
    err = word_error(d, p, m_mode);
    if (clr) m_cnt = 0;
    else if (err) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    e.d   = d;
    e.we  = err;
    e.cnt = CNT_W'(m_cnt);
    if (fw_d.size() == FRAME_LEN) begin
      e.last = 1'b1;
      e.fe   = err || (d != model_lrc());
      foreach (fw_err[i]) e.fe |= fw_err[i];
      fw_d.delete();
      fw_err.delete();
    end else begin
      e.last = 1'b0;
      e.fe   = 1'b0;
      fw_d.push_back(d);
      fw_err.push_back(err);
    end
    sb.push_back(e);
  endtask

  // One clock of stimulus; inputs change 2 time units after the rising edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic p,
                      input logic om, input logic clr, input logic ordy, output bit acc);
    @(posedge clk);
    #2;
    out_ready = ordy;
    in_valid  = v;
    in_data   = d;
    in_par    = p;
    odd_mode  = om;
    clr_count = 1'b0;
    #1;
    acc       = v && in_ready;
    clr_count = clr && acc;
    if (acc) model_accept(d, p, om, clr && acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, odd_mode, 1'b0, 1'b1, acc);
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic p, input logic om,
                      input logic clr);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 50) begin
      step(1'b1, d, p, om, clr, 1'b1, acc);
      guard++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    fw_d.delete();
    fw_err.delete();
    m_mode = 1'b0;
    m_cnt  = 0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", {29'd0, out_word_err, out_last, out_frame_err}, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
  endtask

  // Monitor: compares on every transfer and checks that a stalled word stays put.
  logic              held = 1'b0;
  logic [DATA_W-1:0] h_d;
  logic [3:0]        h_flags;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_data", 32'(out_data), 32'(h_d));
          chk("stall_flags", {28'd0, out_valid, out_word_err, out_last, out_frame_err},
              {28'd0, h_flags});
        end
        if (out_valid && out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_word_err", 32'(out_word_err), 32'(e.we));
            chk("out_last", 32'(out_last), 32'(e.last));
            chk("out_frame_err", 32'(out_frame_err), 32'(e.fe));
            chk("err_count", 32'(err_count), 32'(e.cnt));
          end
        end else if (out_valid) begin
          held    = 1'b1;
          h_d     = out_data;
          h_flags = {1'b1, out_word_err, out_last, out_frame_err};
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    bit                acc;
    logic [DATA_W-1:0] d;
    logic              om;
    logic              mode_for;
    logic              bad;
    int                guard;

    do_reset();

    // Clean even frame
    send(8'h01, 1, 0, 0); send(8'h03, 0, 0, 0); send(8'h07, 1, 0, 0); send(8'h0F, 0, 0, 0);
    send(8'h0A, 0, 0, 0);
    // Word parity error on word 2
    send(8'h01, 1, 0, 0); send(8'h03, 0, 0, 0); send(8'h07, 0, 0, 0); send(8'h0F, 0, 0, 0);
    send(8'h0A, 0, 0, 0);
    // LRC mismatch with clean check-word parity
    send(8'h01, 1, 0, 0); send(8'h03, 0, 0, 0); send(8'h07, 1, 0, 0); send(8'h0F, 0, 0, 0);
    send(8'h0B, 1, 0, 0);
    // Odd mode latched at word 0; odd_mode dropped mid-frame
    send(8'h01, 0, 1, 0); send(8'h03, 1, 0, 0); send(8'h07, 0, 0, 0); send(8'h0F, 1, 0, 0);
    send(8'h0A, 1, 0, 0);
    idle(2);

    // Backpressure: three stalled cycles with a word waiting at the input
    send(8'h01, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_no_accept", 32'(acc), 32'd0);
    end
    send(8'h03, 0, 0, 0); send(8'h07, 1, 0, 0); send(8'h0F, 0, 0, 0); send(8'h0A, 0, 0, 0);
    idle(2);

    // Counter saturation, clear-wins, and mid-frame reset
    do_reset();
    send(8'h01, 0, 0, 0); send(8'h03, 1, 0, 0); send(8'h07, 0, 0, 0); send(8'h0F, 1, 0, 0);
    send(8'h0A, 1, 0, 0);
    idle(1);
    chk("cnt_saturated", 32'(err_count), 32'(CNT_MAX));
    send(8'h01, 0, 0, 1);
    idle(1);
    chk("cnt_clear_wins", 32'(err_count), 32'd0);
    idle(1);
    do_reset();
    send(8'h55, 1, 0, 0); send(8'h33, 1, 0, 0);
    do_reset();
    send(8'h01, 1, 0, 0); send(8'h03, 0, 0, 0); send(8'h07, 1, 0, 0); send(8'h0F, 0, 0, 0);
    send(8'h0A, 0, 0, 0);
    idle(2);

    // Randomized traffic with random backpressure, errors and clears
    for (int i = 0; i < 400; i++) begin
      om       = 1'($urandom_range(0, 1));
      mode_for = (fw_d.size() == 0) ? om : m_mode;
      if (fw_d.size() == FRAME_LEN && $urandom_range(0, 4) != 0) d = model_lrc();
      else d = DATA_W'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      step(1'($urandom_range(0, 9) < 7), d, (^d) ^ mode_for ^ bad, om,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0), acc);
    end

    // Drain whatever is still expected
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
